// File: rtl/blowfish_skeygen_param.sv
// Blowfish P-array key mixer: XORs a latched key cyclically into PI[0..NUM_P-1], one entry per cycle.
// Latency: NUM_P enabled cycles from accepted start to skey_ready; indexed read port has 1-cycle latency.
// Backpressure: Enable low freezes FSM, counters and P-array. Optional length check: SKEYGEN_KEYLEN_CHECK_EN.
module blowfish_skeygen_param #(
    parameter int NUM_P     = 20,
    parameter int KEY_WORDS = 14
) (
    input  logic                               Clk,
    input  logic                               RstN,
    input  logic                               Enable,
    input  logic                               start,
    input  logic [KEY_WORDS*32-1:0]            key,
    input  logic [$clog2(KEY_WORDS+1)-1:0]     key_len,
    output logic                               busy,
    output logic                               skey_ready,
    output logic                               key_err,
    input  logic [$clog2(NUM_P)-1:0]           p_idx,
    output logic [31:0]                        p_data
);

    localparam int KLW = $clog2(KEY_WORDS + 1);
    localparam int IW  = $clog2(NUM_P);
    localparam int JW  = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MIX,
        S_READY
    } state_t;

    function automatic logic [31:0] pi_const(input int idx);
        case (idx)
            0:       pi_const = 32'h243F6A88;
            1:       pi_const = 32'h85A308D3;
            2:       pi_const = 32'h13198A2E;
            3:       pi_const = 32'h03707344;
            4:       pi_const = 32'hA4093822;
            5:       pi_const = 32'h299F31D0;
            6:       pi_const = 32'h082EFA98;
            7:       pi_const = 32'hEC4E6C89;
            8:       pi_const = 32'h452821E6;
            9:       pi_const = 32'h38D01377;
            10:      pi_const = 32'hBE5466CF;
            11:      pi_const = 32'h34E90C6C;
            12:      pi_const = 32'hC0AC29B7;
            13:      pi_const = 32'hC97C50DD;
            14:      pi_const = 32'h3F84D5B5;
            15:      pi_const = 32'hB5470917;
            16:      pi_const = 32'h9216D5D9;
            17:      pi_const = 32'h8979FB1B;
            18:      pi_const = 32'hD1310BA6;
            19:      pi_const = 32'h98DFB5AC;
            default: pi_const = 32'h0000_0000;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [IW-1:0]    i_q, i_d;
    logic [JW-1:0]    j_q, j_d;
    logic [KLW-1:0]   len_q, len_d;
    logic [31:0]      key_q [KEY_WORDS];
    logic [31:0]      key_d [KEY_WORDS];
    logic [31:0]      p_q [NUM_P];
    logic [31:0]      p_d [NUM_P];
    logic [31:0]      p_data_q, p_data_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             key_err_q, key_err_d;

    logic             len_ok;
    logic [KLW-1:0]   len_eff;

    // Effective key length: rejected when checking is built in, otherwise clamped to 1..KEY_WORDS.
    always_comb begin
        len_ok  = 1'b1;
        len_eff = key_len;
`ifdef SKEYGEN_KEYLEN_CHECK_EN
        len_ok = (key_len != '0) && (int'(key_len) <= KEY_WORDS);
`else
        if (key_len == '0) begin
            len_eff = KLW'(1);
        end else if (int'(key_len) > KEY_WORDS) begin
            len_eff = KLW'(KEY_WORDS);
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        len_d     = len_q;
        key_d     = key_q;
        p_d       = p_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        key_err_d = 1'b0;
        p_data_d  = (int'(p_idx) < NUM_P) ? p_q[p_idx] : 32'h0000_0000;

        if (Enable) begin
            case (state_q)
                S_IDLE, S_READY: begin
                    if (start) begin
                        if (len_ok) begin
                            for (int w = 0; w < KEY_WORDS; w++) begin
                                key_d[w] = key[32*w +: 32];
                            end
                            len_d   = len_eff;
                            i_d     = '0;
                            j_d     = '0;
                            ready_d = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_MIX;
                        end else begin
                            key_err_d = 1'b1;
                        end
                    end
                end
                S_MIX: begin
                    p_d[i_q] = pi_const(int'(i_q)) ^ key_q[j_q];
                    i_d      = i_q + 1'b1;
                    j_d      = (int'(j_q) == int'(len_q) - 1) ? '0 : j_q + 1'b1;
                    if (int'(i_q) == NUM_P - 1) begin
                        i_d     = '0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        state_d = S_READY;
                    end
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            len_q     <= '0;
            p_data_q  <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            key_err_q <= 1'b0;
            for (int w = 0; w < KEY_WORDS; w++) begin
                key_q[w] <= '0;
            end
            for (int k = 0; k < NUM_P; k++) begin
                p_q[k] <= pi_const(k);
            end
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            len_q     <= len_d;
            p_data_q  <= p_data_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            key_err_q <= key_err_d;
            key_q     <= key_d;
            p_q       <= p_d;
        end
    end

    assign busy       = busy_q;
    assign skey_ready = ready_q;
    assign key_err    = key_err_q;
    assign p_data     = p_data_q;

endmodule

// File: tb/tb_blowfish_skeygen_param.sv
// Directed bench for blowfish_skeygen_param with NUM_P=20, KEY_WORDS=14.
module tb_blowfish_skeygen_param;

    logic          Clk = 1'b0;
    logic          RstN;
    logic          Enable;
    logic          start;
    logic [447:0]  key;
    logic [3:0]    key_len;
    logic          busy;
    logic          skey_ready;
    logic          key_err;
    logic [4:0]    p_idx;
    logic [31:0]   p_data;

    int errors = 0;
    int checks = 0;
    int n;
    logic ke_seen;

    logic [31:0] tb_pi [20] = '{
        32'h243F6A88, 32'h85A308D3, 32'h13198A2E, 32'h03707344, 32'hA4093822,
        32'h299F31D0, 32'h082EFA98, 32'hEC4E6C89, 32'h452821E6, 32'h38D01377,
        32'hBE5466CF, 32'h34E90C6C, 32'hC0AC29B7, 32'hC97C50DD, 32'h3F84D5B5,
        32'hB5470917, 32'h9216D5D9, 32'h8979FB1B, 32'hD1310BA6, 32'h98DFB5AC
    };
    logic [31:0] w4 [4] = '{32'h89ABCDEF, 32'h01234567, 32'h76543210, 32'hFEDCBA98};

    blowfish_skeygen_param #(.NUM_P(20), .KEY_WORDS(14)) dut (
        .Clk        (Clk),
        .RstN       (RstN),
        .Enable     (Enable),
        .start      (start),
        .key        (key),
        .key_len    (key_len),
        .busy       (busy),
        .skey_ready (skey_ready),
        .key_err    (key_err),
        .p_idx      (p_idx),
        .p_data     (p_data)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input string tag);
        p_idx = 5'(idx);
        step();
        chk(tag, p_data, exp);
    endtask

    task automatic load_l4();
        key = '0;
        for (int w = 0; w < 4; w++) key[32*w +: 32] = w4[w];
        key_len = 4'd4;
    endtask

    // Pulses start, then counts busy cycles (bounded); optional Enable gap and mid-run disturbance.
    task automatic run(input int gap_at, input bit poke, output int cnt);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy_rise", 32'(busy), 32'd1);
        chk("start_ready_fall", 32'(skey_ready), 32'd0);
        cnt = 0;
        ke_seen = 1'b0;
        while (busy && cnt < 100) begin
            if (poke && cnt == 2) begin
                key = ~key;
                key_len = 4'd1;
            end
            start  = poke && (cnt == 3);
            Enable = !(gap_at >= 0 && cnt >= gap_at && cnt < gap_at + 3);
            ke_seen = ke_seen | key_err;
            step();
            cnt++;
        end
        start  = 1'b0;
        Enable = 1'b1;
    endtask

    initial begin
        RstN = 1'b0; Enable = 1'b1; start = 1'b0; key = '0; key_len = '0; p_idx = '0;
        repeat (2) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(skey_ready), 32'd0);
        chk("rst_key_err", 32'(key_err), 32'd0);
        chk("rst_p_data", p_data, 32'h0);
        RstN = 1'b1;
        rd(0, 32'h243F6A88, "rst_p0");
        rd(1, 32'h85A308D3, "rst_p1");
        rd(19, 32'h98DFB5AC, "rst_p19");
        chk("rst_ready_after", 32'(skey_ready), 32'd0);
        rd(25, 32'h0, "oob_idx_zero");

        // L=4 with key/key_len changes and a stray start during MIX
        load_l4();
        run(-1, 1'b1, n);
        chk("l4_busy_cycles", 32'(n), 32'd20);
        chk("l4_ready", 32'(skey_ready), 32'd1);
        rd(0, 32'hAD94A767, "l4_p0");
        rd(1, 32'h84804DB4, "l4_p1");
        rd(4, 32'h2DA2F5CD, "l4_p4_wrap");
        rd(19, 32'h66030F34, "l4_p19");

        // L=1
        key = '0; key[31:0] = 32'h89ABCDEF; key[63:32] = 32'hFFFFFFFF; key_len = 4'd1;
        run(-1, 1'b0, n);
        chk("l1_busy_cycles", 32'(n), 32'd20);
        rd(1, 32'h0C08C53C, "l1_p1");
        for (int k = 0; k < 20; k++) rd(k, tb_pi[k] ^ 32'h89ABCDEF, "l1_pk");

        // L=4 again from READY, with a 3-cycle Enable gap
        load_l4();
        run(5, 1'b0, n);
        chk("gap_busy_cycles", 32'(n), 32'd23);
        chk("gap_ready", 32'(skey_ready), 32'd1);
        for (int k = 0; k < 20; k++) rd(k, tb_pi[k] ^ w4[k % 4], "gap_pk");

        // Asynchronous reset in the middle of a run
        key = '0; key[31:0] = 32'h89ABCDEF; key_len = 4'd1;
        start = 1'b1; step(); start = 1'b0;
        repeat (10) step();
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        RstN = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(skey_ready), 32'd0);
        chk("mid_rst_p_data", p_data, 32'h0);
        step();
        RstN = 1'b1;
        rd(0, 32'h243F6A88, "mid_rst_p0");
        rd(1, 32'h85A308D3, "mid_rst_p1");

        // key_len = 0
        key = '0; key[31:0] = 32'h89ABCDEF; key[63:32] = 32'h11111111; key_len = 4'd0;
`ifdef SKEYGEN_KEYLEN_CHECK_EN
        start = 1'b1; step(); start = 1'b0;
        chk("len0_key_err", 32'(key_err), 32'd1);
        chk("len0_no_busy", 32'(busy), 32'd0);
        step();
        chk("len0_key_err_clear", 32'(key_err), 32'd0);
        chk("len0_still_idle", 32'(busy), 32'd0);
        chk("len0_ready", 32'(skey_ready), 32'd0);
        rd(1, 32'h85A308D3, "len0_p1_unchanged");
`else
        run(-1, 1'b0, n);
        chk("len0_busy_cycles", 32'(n), 32'd20);
        chk("len0_no_key_err", 32'(ke_seen), 32'd0);
        rd(1, 32'h0C08C53C, "len0_p1_as_l1");
        rd(2, tb_pi[2] ^ 32'h89ABCDEF, "len0_p2_as_l1");

        // key_len above KEY_WORDS clamps to 14 words
        key = '0;
        for (int w = 0; w < 14; w++) key[32*w +: 32] = 32'h1000_0001 * 32'(w + 1);
        key_len = 4'd15;
        run(-1, 1'b0, n);
        chk("clamp_key_err", 32'(ke_seen), 32'd0);
        rd(13, tb_pi[13] ^ (32'h1000_0001 * 32'd14), "clamp_p13");
        rd(14, tb_pi[14] ^ 32'h1000_0001, "clamp_p14_wrap");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
